// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter: owner IDs and FSM states.
package mem_bus_arbiter_pkg;

  localparam logic ArbIdInstr = 1'b0;
  localparam logic ArbIdData  = 1'b1;

  typedef enum logic [1:0] {
    ArbIdle  = 2'b00,
    ArbHoldI = 2'b01,
    ArbHoldD = 2'b10
  } arb_state_e;

  function automatic arb_state_e hold_state(input logic id);
    return (id == ArbIdData) ? ArbHoldD : ArbHoldI;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Owner-ID FIFO for outstanding memory transactions (1 bit wide, DEPTH entries, power of two).
module mem_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_eff, pop_eff;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_eff = push && !full;
  assign pop_eff  = pop && !empty;
  assign dout     = mem_q[rd_ptr_q];
  assign count    = count_q;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data ports; routes responses by owner ID.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority (data over instr).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic                instr_gnt,
  output logic                instr_r_valid,
  output logic [DATA_W-1:0]   instr_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_r_valid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_r_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_rvalid
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e       state_q, state_d;
  logic             idle_win, sel, sel_req, req_int, push, pop;
  logic             fifo_dout, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             err_q;

`ifdef ARB_RR_EN
  logic rr_last_q;

  // On a tie the port that did not win last time goes first.
  assign idle_win = (instr_req && data_req) ? ~rr_last_q :
                    (data_req ? ArbIdData : ArbIdInstr);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rr_last_q <= ArbIdInstr;
    end else if (push) begin
      rr_last_q <= sel;
    end
  end
`else
  assign idle_win = data_req ? ArbIdData : ArbIdInstr;
`endif

  always_comb begin
    sel     = idle_win;
    state_d = state_q;
    unique case (state_q)
      ArbHoldI: sel = ArbIdInstr;
      ArbHoldD: sel = ArbIdData;
      default:  sel = idle_win;
    endcase
    sel_req = (sel == ArbIdData) ? data_req : instr_req;
    // Blocking uses the registered count, so a same-cycle pop does not free a slot.
    req_int = sel_req && !fifo_full;
    push    = req_int && mem_gnt;
    if (!fifo_full) begin
      unique case (state_q)
        ArbIdle: begin
          if (sel_req && !mem_gnt) state_d = hold_state(sel);
        end
        ArbHoldI, ArbHoldD: begin
          if (!sel_req || mem_gnt) state_d = ArbIdle;
        end
        default: state_d = ArbIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ArbIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_r_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign pop = mem_r_valid && !fifo_empty;

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Everything facing the core or the memory is held low while reset is asserted.
  assign mem_req       = res && req_int;
  assign mem_we        = res && (sel == ArbIdData) && data_we;
  assign mem_be        = !res ? '0 : ((sel == ArbIdData) ? data_be : '1);
  assign mem_addr      = !res ? '0 : ((sel == ArbIdData) ? data_addr : instr_addr);
  assign mem_wdata     = (res && (sel == ArbIdData)) ? data_wdata : '0;
  assign instr_gnt     = res && push && (sel == ArbIdInstr);
  assign data_gnt      = res && push && (sel == ArbIdData);
  assign instr_r_valid = res && pop && (fifo_dout == ArbIdInstr);
  assign data_r_valid  = res && pop && (fifo_dout == ArbIdData);
  assign instr_rdata   = res ? mem_rdata : '0;
  assign data_rdata    = res ? mem_rdata : '0;
  assign err_rvalid    = err_q;

  count_in_range_a: assert property (@(posedge clk) disable iff (!res)
    fifo_count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with a response scoreboard.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic        instr_req, instr_gnt, instr_r_valid;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_we, data_gnt, data_r_valid;
  logic [3:0]  data_be, mem_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_r_valid, err_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } resp_t;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk           (clk),
    .res           (res),
    .instr_req     (instr_req),
    .instr_addr    (instr_addr),
    .instr_gnt     (instr_gnt),
    .instr_r_valid (instr_r_valid),
    .instr_rdata   (instr_rdata),
    .data_req      (data_req),
    .data_we       (data_we),
    .data_be       (data_be),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_gnt      (data_gnt),
    .data_r_valid  (data_r_valid),
    .data_rdata    (data_rdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_r_valid   (mem_r_valid),
    .mem_rdata     (mem_rdata),
    .err_rvalid    (err_rvalid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic id, input logic [31:0] d);
    resp_t r;
    r.id   = id;
    r.data = d;
    exp_q.push_back(r);
  endtask

  // Monitor: every response pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (instr_r_valid || data_r_valid) begin
      resp_t r;
      vectors++;
      if (instr_r_valid && data_r_valid) begin
        miscompares++;
        $display("FAIL resp_onehot: got both r_valid, expected exactly one");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: got r_valid id=%0d, expected none", data_r_valid);
      end else begin
        r = exp_q.pop_front();
        if (data_r_valid !== r.id ||
            (r.id ? data_rdata : instr_rdata) !== r.data) begin
          miscompares++;
          $display("FAIL resp: got id=%0d data=%0h, expected id=%0d data=%0h", data_r_valid,
                   r.id ? data_rdata : instr_rdata, r.id, r.data);
        end
      end
    end
  end

  initial begin
    res = 1'b0;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_rdata = '0;

    // Reset forcing: requests and grant present, outputs held low.
    instr_req = 1'b1; instr_addr = 32'h40; mem_gnt = 1'b1;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_instr_gnt", instr_gnt, 0);
    check("rst_err", err_rvalid, 0);
    next_cycle();
    instr_req = 1'b0; mem_gnt = 1'b0; res = 1'b1;
    next_cycle();

    // Lone fetch, zero-latency grant, response two cycles later.
    instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
    @(negedge clk);
    check("t1_instr_gnt", instr_gnt, 1);
    check("t1_data_gnt", data_gnt, 0);
    check("t1_mem_addr", mem_addr, 32'h100);
    expect_resp(1'b0, 32'hAAAA_0001);
    next_cycle();
    instr_req = 1'b0; mem_gnt = 1'b0;
    next_cycle();
    mem_r_valid = 1'b1; mem_rdata = 32'hAAAA_0001;
    @(negedge clk);
    check("t1_data_r_valid", data_r_valid, 0);
    next_cycle();
    mem_r_valid = 1'b0;
    @(negedge clk);
    check("t1_rv_one_cycle", instr_r_valid, 0);

    // Simultaneous requests, memory stalls for 3 cycles: data held, instr next.
    next_cycle();
    instr_req = 1'b1; instr_addr = 32'h200;
    data_req = 1'b1; data_addr = 32'h300; data_we = 1'b0; data_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_addr", mem_addr, 32'h300);
      check("t2_hold_instr_gnt", instr_gnt, 0);
      check("t2_hold_mem_req", mem_req, 1);
      next_cycle();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check("t2_data_gnt", data_gnt, 1);
    check("t2_instr_gnt0", instr_gnt, 0);
    expect_resp(1'b1, 32'hD000_0001);
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    check("t2_instr_next", instr_gnt, 1);
    check("t2_instr_addr", mem_addr, 32'h200);
    expect_resp(1'b0, 32'hD000_0002);
    next_cycle();
    instr_req = 1'b0; mem_gnt = 1'b0;
    mem_r_valid = 1'b1; mem_rdata = 32'hD000_0001;
    next_cycle();
    mem_rdata = 32'hD000_0002;
    next_cycle();
    mem_r_valid = 1'b0;

    // Outstanding limit of two.
    instr_req = 1'b1; instr_addr = 32'h400; mem_gnt = 1'b1;
    @(negedge clk);
    check("t3_gnt_a", instr_gnt, 1);
    expect_resp(1'b0, 32'hE000_0001);
    next_cycle();
    @(negedge clk);
    check("t3_gnt_b", instr_gnt, 1);
    expect_resp(1'b0, 32'hE000_0002);
    next_cycle();
    @(negedge clk);
    check("t3_full_mem_req", mem_req, 0);
    check("t3_full_gnt", instr_gnt, 0);
    next_cycle();
    mem_r_valid = 1'b1; mem_rdata = 32'hE000_0001;
    @(negedge clk);
    check("t3_pop_no_unblock", mem_req, 0);
    next_cycle();
    mem_r_valid = 1'b0;
    @(negedge clk);
    check("t3_reassert", mem_req, 1);
    check("t3_gnt_c", instr_gnt, 1);
    expect_resp(1'b0, 32'hE000_0003);
    next_cycle();
    instr_req = 1'b0; mem_gnt = 1'b0;
    mem_r_valid = 1'b1; mem_rdata = 32'hE000_0002;
    @(negedge clk);
    check("t3_idle_mem_req", mem_req, 0);
    next_cycle();
    mem_rdata = 32'hE000_0003;
    next_cycle();
    mem_r_valid = 1'b0;

    // Stray response with nothing outstanding.
    @(negedge clk);
    check("t4_err_before", err_rvalid, 0);
    next_cycle();
    mem_r_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_no_instr_rv", instr_r_valid, 0);
    check("t4_no_data_rv", data_r_valid, 0);
    next_cycle();
    mem_r_valid = 1'b0;
    @(negedge clk);
    check("t4_err_set", err_rvalid, 1);
    next_cycle();
    @(negedge clk);
    check("t4_err_sticky", err_rvalid, 1);

    // Reset clears the error; store granted then reset before its response.
    next_cycle();
    res = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", err_rvalid, 0);
    next_cycle();
    res = 1'b1;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h500; data_wdata = 32'h0000_CAFE; mem_gnt = 1'b1;
    @(negedge clk);
    check("t5_store_gnt", data_gnt, 1);
    check("t5_store_we", mem_we, 1);
    check("t5_store_be", mem_be, 4'b0011);
    check("t5_store_wdata", mem_wdata, 32'h0000_CAFE);
    next_cycle();
    res = 1'b0;
    @(negedge clk);
    check("t5_rst_mem_req", mem_req, 0);
    check("t5_rst_data_gnt", data_gnt, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_mem_we", mem_we, 0);
    check("t5_rst_mem_be", mem_be, 0);
    next_cycle();
    res = 1'b1; data_req = 1'b0; data_we = 1'b0; mem_gnt = 1'b0;
    mem_r_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("t5_late_no_rv", data_r_valid, 0);
    next_cycle();
    mem_r_valid = 1'b0;
    @(negedge clk);
    check("t5_late_err", err_rvalid, 1);

`ifdef ARB_RR_EN
    // Round-robin: continuous simultaneous requests alternate D,I,D,I.
    next_cycle();
    instr_req = 1'b1; instr_addr = 32'h600;
    data_req = 1'b1; data_addr = 32'h700; data_be = 4'hF; mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_r_valid = (k > 0);
      mem_rdata = 32'hF000_0000 + 32'(k - 1);
      @(negedge clk);
      check("rr_data_gnt", data_gnt, (k % 2 == 0));
      check("rr_instr_gnt", instr_gnt, (k % 2 == 1));
      expect_resp((k % 2 == 0), 32'hF000_0000 + 32'(k));
      next_cycle();
    end
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
    mem_r_valid = 1'b1; mem_rdata = 32'hF000_0003;
    next_cycle();
    mem_r_valid = 1'b0;
`endif

    next_cycle();
    next_cycle();
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish within 100000 time units");
    $fatal(1);
  end

endmodule
